// File: rtl/tank_level_simulator_pkg.sv
// Shared tank model defaults and sensor bundle type.
// Same level, threshold and rate values the irrigation controller assumes.
package tank_level_simulator_pkg;

  localparam int DEF_CLK_DIV        = 50_000_000;
  localparam int DEF_LEVEL_MAX      = 15;
  localparam int DEF_L_THRESH       = 3;
  localparam int DEF_M_THRESH       = 8;
  localparam int DEF_H_THRESH       = 13;
  localparam int DEF_FILL_RATE      = 2;
  localparam int DEF_SPRINKLER_RATE = 2;
  localparam int DEF_DRIP_RATE      = 1;

  typedef struct packed {
    logic high;
    logic middle;
    logic low;
    logic dry;
  } sensors_t;

  localparam sensors_t SENS_RST = '{
    high: 1'b0, middle: 1'b0, low: 1'b0, dry: 1'b1
  };

endpackage

// File: rtl/tank_level_simulator_step_prescaler.sv
// Free-running step-pulse generator that freezes while disabled.
// Emits one pulse every CLK_DIV enabled clocks.
module step_prescaler #(
  parameter int  CLK_DIV = 2,
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic step
);

  logic [CW-1:0] cnt;
  logic          last;

  if (CLK_DIV < 2) begin : g_bad_div
    $error("step_prescaler: CLK_DIV must be >= 2");
  end

  assign last = (cnt == CW'(CLK_DIV - 1));
  assign step = enable & last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tank_level_simulator.sv
// Water-tank plant model: integrates valve commands into a level and
// drives the float switches the irrigation controller reads.
module tank_level_simulator
  import tank_level_simulator_pkg::*;
#(
  parameter int  CLK_DIV        = DEF_CLK_DIV,
  parameter int  LEVEL_MAX      = DEF_LEVEL_MAX,
  parameter int  L_THRESH       = DEF_L_THRESH,
  parameter int  M_THRESH       = DEF_M_THRESH,
  parameter int  H_THRESH       = DEF_H_THRESH,
  parameter int  FILL_RATE      = DEF_FILL_RATE,
  parameter int  SPRINKLER_RATE = DEF_SPRINKLER_RATE,
  parameter int  DRIP_RATE      = DEF_DRIP_RATE,
  localparam int LW = $clog2(LEVEL_MAX + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          inlet_open,
  input  logic          sprinkler_open,
  input  logic          drip_open,
  input  logic          stuck_middle,
  input  logic          clear_flags,
  output logic          high,
  output logic          middle,
  output logic          low,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic          dry
);

  localparam int SW = LW + 2;

  if (!(L_THRESH <= M_THRESH &&
        M_THRESH <= H_THRESH &&
        H_THRESH <= LEVEL_MAX)) begin : g_bad_thresh
    $error("tank_level_simulator: thresholds out of order");
  end

  logic                 step;
  logic signed [SW-1:0] net;
  logic signed [SW-1:0] sum;
  logic                 over;
  sensors_t             sens;

  step_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_pre (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .step   (step)
  );

  always_comb begin
    net = '0;
    if (inlet_open)     net = net + SW'(FILL_RATE);
    if (sprinkler_open) net = net - SW'(SPRINKLER_RATE);
    if (drip_open)      net = net - SW'(DRIP_RATE);
    sum  = $signed({2'b00, level}) + net;
    over = sum > $signed(SW'(LEVEL_MAX));
  end

  // Saturate at both ends; only the top clamp is flagged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (step) begin
        if (over)          level <= LW'(LEVEL_MAX);
        else if (sum[SW-1]) level <= '0;
        else               level <= sum[LW-1:0];
      end
      if (step && over)     overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sens <= SENS_RST;
    end else begin
      sens.high   <= level >= LW'(H_THRESH);
      sens.middle <= (level >= LW'(M_THRESH)) & ~stuck_middle;
      sens.low    <= level >= LW'(L_THRESH);
      sens.dry    <= level == '0;
    end
  end

  assign high   = sens.high;
  assign middle = sens.middle;
  assign low    = sens.low;
  assign dry    = sens.dry;

endmodule

// File: tb/tb_tank_level_simulator.sv
// Directed scoreboard bench for tank_level_simulator with CLK_DIV=4.
module tb_tank_level_simulator;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       inlet_open;
  logic       sprinkler_open;
  logic       drip_open;
  logic       stuck_middle;
  logic       clear_flags;
  logic       high;
  logic       middle;
  logic       low;
  logic [3:0] level;
  logic       overflow;
  logic       dry;

  tank_level_simulator #(
    .CLK_DIV        (4),
    .LEVEL_MAX      (15),
    .L_THRESH       (3),
    .M_THRESH       (8),
    .H_THRESH       (13),
    .FILL_RATE      (2),
    .SPRINKLER_RATE (2),
    .DRIP_RATE      (1)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .inlet_open     (inlet_open),
    .sprinkler_open (sprinkler_open),
    .drip_open      (drip_open),
    .stuck_middle   (stuck_middle),
    .clear_flags    (clear_flags),
    .high           (high),
    .middle         (middle),
    .low            (low),
    .level          (level),
    .overflow       (overflow),
    .dry            (dry)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ph    = 0;

  // Expected {high,middle,low,dry} for a given level.
  function automatic logic [7:0] sens(input int lvl, input bit st);
    logic [7:0] r;
    r    = '0;
    r[3] = (lvl >= 13);
    r[2] = (lvl >= 8) && !st;
    r[1] = (lvl >= 3);
    r[0] = (lvl == 0);
    return r;
  endfunction

  function automatic logic [7:0] obs_s();
    return {4'b0, high, middle, low, dry};
  endfunction

  task automatic push(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.v   = 8'(v);
    q.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        n_bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.v);
      end
    end
  endtask

  // Advance n falling edges; ph mirrors the prescaler count.
  task automatic tk(input int n);
    repeat (n) @(negedge clock);
    if (enable) ph = (ph + n) % 4;
  endtask

  // Run up to the next step, check level and lagging sensors.
  task automatic run_step(input string tag, input int lvl,
                          input int prev, input bit st);
    tk(3 - ph);
    push({tag, "_level"}, lvl);
    push({tag, "_sens_old"}, sens(prev, st));
    tk(1);
    chk(8'(level));
    chk(obs_s());
    push({tag, "_sens_new"}, sens(lvl, st));
    tk(1);
    chk(obs_s());
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    inlet_open     = 1'b0;
    sprinkler_open = 1'b0;
    drip_open      = 1'b0;
    stuck_middle   = 1'b0;
    clear_flags    = 1'b0;
    repeat (2) @(negedge clock);

    // Run briefly, then reset in the middle of a cycle.
    reset      = 1'b0;
    enable     = 1'b1;
    inlet_open = 1'b1;
    ph         = 0;
    push("pre_level", 4);
    push("pre_sens", sens(4, 0));
    tk(9);
    chk(8'(level));
    chk(obs_s());
    #2 reset = 1'b1;
    #1;
    push("rst_level", 0);
    chk(8'(level));
    push("rst_sens", 8'h01);
    chk(obs_s());
    push("rst_ovf", 0);
    chk(8'(overflow));
    @(negedge clock);
    reset = 1'b0;
    ph    = 0;

    // Fill from empty.
    for (int k = 1; k <= 7; k++)
      run_step("fill", 2 * k, 2 * k - 2, 0);
    run_step("sat", 15, 14, 0);
    push("sat_ovf", 1);
    chk(8'(overflow));
    run_step("hold", 15, 15, 0);
    push("hold_ovf", 1);
    chk(8'(overflow));

    // Clear off-step, then re-set on the next step.
    clear_flags = 1'b1;
    tk(1);
    clear_flags = 1'b0;
    push("clr_ovf", 0);
    chk(8'(overflow));
    run_step("reset_ovf", 15, 15, 0);
    push("reset_ovf_flag", 1);
    chk(8'(overflow));

    // Clear coinciding with a saturating step: set wins.
    tk(2);
    clear_flags = 1'b1;
    tk(1);
    clear_flags = 1'b0;
    push("coinc_ovf", 1);
    chk(8'(overflow));
    push("coinc_level", 15);
    chk(8'(level));
    tk(1);

    // Drain with sprinkler and drip.
    clear_flags = 1'b1;
    tk(1);
    clear_flags = 1'b0;
    push("drain_ovf_clr", 0);
    chk(8'(overflow));
    inlet_open     = 1'b0;
    sprinkler_open = 1'b1;
    drip_open      = 1'b1;
    run_step("drain", 12, 15, 0);
    run_step("drain", 9, 12, 0);
    run_step("drain", 6, 9, 0);
    run_step("drain", 3, 6, 0);
    run_step("drain", 0, 3, 0);
    run_step("under", 0, 0, 0);
    push("under_ovf", 0);
    chk(8'(overflow));

    // Inlet pulse between steps is ignored.
    sprinkler_open = 1'b0;
    drip_open      = 1'b0;
    inlet_open     = 1'b1;
    tk(1);
    inlet_open = 1'b0;
    tk(2);
    push("between_level", 0);
    chk(8'(level));
    tk(1);

    // Refill, then stuck middle sensor.
    inlet_open = 1'b1;
    for (int k = 1; k <= 7; k++)
      run_step("refill", 2 * k, 2 * k - 2, 0);
    run_step("refill", 15, 14, 0);
    stuck_middle = 1'b1;
    push("stuck_sens", sens(15, 1));
    tk(1);
    chk(obs_s());
    stuck_middle = 1'b0;
    push("unstuck_sens", sens(15, 0));
    tk(1);
    chk(obs_s());
    tk(2);

    // Freeze with a draining valve, then resume.
    inlet_open = 1'b0;
    drip_open  = 1'b1;
    enable     = 1'b0;
    tk(20);
    push("frozen_level", 15);
    chk(8'(level));
    enable = 1'b1;
    tk(2);
    push("resume_hold", 15);
    chk(8'(level));
    tk(1);
    push("resume_step", 14);
    chk(8'(level));
    tk(1);

    // Drain to 1, then all valves open.
    clear_flags = 1'b1;
    tk(1);
    clear_flags = 1'b0;
    push("pre7_ovf", 0);
    chk(8'(overflow));
    sprinkler_open = 1'b1;
    run_step("d7", 11, 14, 0);
    run_step("d7", 8, 11, 0);
    run_step("d7", 5, 8, 0);
    run_step("d7", 2, 5, 0);
    sprinkler_open = 1'b0;
    run_step("d7", 1, 2, 0);
    inlet_open     = 1'b1;
    sprinkler_open = 1'b1;
    run_step("all", 0, 1, 0);
    push("all_ovf", 0);
    chk(8'(overflow));

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0",
             q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
